interrupt_controller: RTL and testbench

Prioritised, nestable interrupt controller for the 8-bit program sequencer. It edge-detects external requests and arbitrates them by fixed priority. When an interrupt is taken it forces a vector address onto the sequencer's next-address path and saves the return address on an internal stack. On a return-from-interrupt strobe from the instruction decoder it restores that address.

---
 rtl/interrupt_controller.sv | 168 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Prioritised, nestable interrupt controller for the 8-bit program sequencer.
// Edge-detected requests, fixed priority (index 0 highest), LIFO return-address stack.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [7:0]  VEC_BASE    = 8'hF0,
    localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic [7:0]         seq_next_addr,
    output logic               vector_valid,
    output logic [7:0]         vector_addr,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               ret_valid,
    output logic [7:0]         ret_addr,
    output logic [DW-1:0]      depth,
    output logic               in_service,
    output logic               underflow
);

    localparam int unsigned LW = $clog2(NUM_IRQ + 1);
    localparam int unsigned SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StVector, StReturn} state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               gie_q, gie_d;
    logic [LW-1:0]      cur_level_q, cur_level_d;
    logic [LW-1:0]      sel_q, sel_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               underflow_q, underflow_d;
    logic               vector_valid_q, vector_valid_d;
    logic [7:0]         vector_addr_q, vector_addr_d;
    logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
    logic               ret_valid_q, ret_valid_d;
    logic [7:0]         ret_addr_q, ret_addr_d;
    logic [7:0]         stack_addr_q [STACK_DEPTH];
    logic [7:0]         stack_addr_d [STACK_DEPTH];
    logic [LW-1:0]      stack_lvl_q  [STACK_DEPTH];
    logic [LW-1:0]      stack_lvl_d  [STACK_DEPTH];

    logic               found;
    logic [LW-1:0]      cand;
    logic [7:0]         cand8;
    logic               takeable;
    logic [SW-1:0]      push_idx;
    logic [SW-1:0]      top_idx;
    logic [NUM_IRQ-1:0] rise;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                found = 1'b1;
                cand  = LW'(i);
            end
        end
        cand8    = 8'(cand);
        takeable = found && gie_q && (cand < cur_level_q) && (depth_q < DW'(STACK_DEPTH));
        push_idx = SW'(depth_q);
        top_idx  = SW'(depth_q - 1'b1);
        rise     = irq & ~irq_q;

        state_d        = state_q;
        irq_d          = irq;
        pending_d      = pending_q | rise;
        gie_d          = di ? 1'b0 : (ei ? 1'b1 : gie_q);
        cur_level_d    = cur_level_q;
        sel_d          = sel_q;
        depth_d        = depth_q;
        underflow_d    = underflow_q;
        vector_valid_d = 1'b0;
        vector_addr_d  = '0;
        irq_ack_d      = '0;
        ret_valid_d    = 1'b0;
        ret_addr_d     = '0;
        stack_addr_d   = stack_addr_q;
        stack_lvl_d    = stack_lvl_q;

        unique case (state_q)
            StIdle: begin
                // A return beats a takeable interrupt in the same cycle.
                if (reti) begin
                    if (depth_q != '0) begin
                        state_d     = StReturn;
                        ret_valid_d = 1'b1;
                        ret_addr_d  = stack_addr_q[top_idx];
                    end else begin
                        underflow_d = 1'b1;
                    end
                end else if (takeable) begin
                    state_d        = StVector;
                    sel_d          = cand;
                    vector_valid_d = 1'b1;
                    vector_addr_d  = VEC_BASE + (cand8 << 2);
                    irq_ack_d      = NUM_IRQ'(1) << cand;
                end
            end
            StVector: begin
                stack_addr_d[push_idx] = seq_next_addr;
                stack_lvl_d[push_idx]  = cur_level_q;
                cur_level_d            = sel_q;
                depth_d                = depth_q + 1'b1;
                // A fresh edge on the acknowledged line survives the clear.
                pending_d              = (pending_q & ~irq_ack_q) | rise;
                state_d                = StIdle;
            end
            StReturn: begin
                cur_level_d = stack_lvl_q[top_idx];
                depth_d     = depth_q - 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q        <= StIdle;
            irq_q          <= '0;
            pending_q      <= '0;
            gie_q          <= 1'b0;
            cur_level_q    <= LW'(NUM_IRQ);
            sel_q          <= '0;
            depth_q        <= '0;
            underflow_q    <= 1'b0;
            vector_valid_q <= 1'b0;
            vector_addr_q  <= '0;
            irq_ack_q      <= '0;
            ret_valid_q    <= 1'b0;
            ret_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            irq_q          <= irq_d;
            pending_q      <= pending_d;
            gie_q          <= gie_d;
            cur_level_q    <= cur_level_d;
            sel_q          <= sel_d;
            depth_q        <= depth_d;
            underflow_q    <= underflow_d;
            vector_valid_q <= vector_valid_d;
            vector_addr_q  <= vector_addr_d;
            irq_ack_q      <= irq_ack_d;
            ret_valid_q    <= ret_valid_d;
            ret_addr_q     <= ret_addr_d;
            stack_addr_q   <= stack_addr_d;
            stack_lvl_q    <= stack_lvl_d;
        end
    end

    assign vector_valid = vector_valid_q;
    assign vector_addr  = vector_addr_q;
    assign irq_ack      = irq_ack_q;
    assign ret_valid    = ret_valid_q;
    assign ret_addr     = ret_addr_q;
    assign depth        = depth_q;
    assign in_service   = (depth_q != '0);
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (STACK_DEPTH=3 so a full stack
// can hold back an otherwise takeable request).
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [3:0] irq;
    logic       ei, di, reti;
    logic [7:0] seq_next_addr;
    logic       vector_valid;
    logic [7:0] vector_addr;
    logic [3:0] irq_ack;
    logic       ret_valid;
    logic [7:0] ret_addr;
    logic [1:0] depth;
    logic       in_service;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_controller #(
        .NUM_IRQ    (4),
        .STACK_DEPTH(3),
        .VEC_BASE   (8'hF0)
    ) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .irq          (irq),
        .ei           (ei),
        .di           (di),
        .reti         (reti),
        .seq_next_addr(seq_next_addr),
        .vector_valid (vector_valid),
        .vector_addr  (vector_addr),
        .irq_ack      (irq_ack),
        .ret_valid    (ret_valid),
        .ret_addr     (ret_addr),
        .depth        (depth),
        .in_service   (in_service),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse a single irq line, expect its vector two edges later, push the given address.
    task automatic take(input string tag, input logic [3:0] mask, input logic [7:0] exp_addr,
                        input logic [7:0] push);
        irq = mask;
        tick();
        check_eq({tag, "_early"}, vector_valid, 1'b0);
        irq = '0;
        tick();
        check_eq({tag, "_vv"}, vector_valid, 1'b1);
        check_eq({tag, "_addr"}, vector_addr, exp_addr);
        check_eq({tag, "_ack"}, irq_ack, mask);
        seq_next_addr = push;
        tick();
        check_eq({tag, "_vv_off"}, vector_valid, 1'b0);
        check_eq({tag, "_addr_off"}, vector_addr, 8'h00);
    endtask

    task automatic do_reti(input string tag, input logic [7:0] exp_addr,
                           input logic [1:0] exp_depth);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check_eq({tag, "_rv"}, ret_valid, 1'b1);
        check_eq({tag, "_raddr"}, ret_addr, exp_addr);
        check_eq({tag, "_no_vv"}, vector_valid, 1'b0);
        tick();
        check_eq({tag, "_rv_off"}, ret_valid, 1'b0);
        check_eq({tag, "_raddr_off"}, ret_addr, 8'h00);
        check_eq({tag, "_depth"}, depth, exp_depth);
    endtask

    initial begin
        sync_reset    = 1'b1;
        irq           = '0;
        ei            = 1'b0;
        di            = 1'b0;
        reti          = 1'b0;
        seq_next_addr = '0;
        tick();
        tick();
        sync_reset = 1'b0;
        check_eq("rst_vv", vector_valid, 1'b0);
        check_eq("rst_rv", ret_valid, 1'b0);
        check_eq("rst_depth", depth, 2'd0);
        check_eq("rst_insvc", in_service, 1'b0);
        check_eq("rst_uf", underflow, 1'b0);

        // Single interrupt
        ei = 1'b1;
        tick();
        ei = 1'b0;
        take("single", 4'b0100, 8'hF8, 8'h23);
        check_eq("single_depth", depth, 2'd1);
        check_eq("single_insvc", in_service, 1'b1);
        do_reti("single_ret", 8'h23, 2'd0);
        check_eq("single_insvc0", in_service, 1'b0);

        // Priority: irq 3 and 1 together
        irq = 4'b1010;
        tick();
        irq = '0;
        tick();
        check_eq("prio_vv", vector_valid, 1'b1);
        check_eq("prio_addr", vector_addr, 8'hF4);
        check_eq("prio_ack", irq_ack, 4'b0010);
        seq_next_addr = 8'h40;
        tick();
        tick();
        tick();
        check_eq("prio_hold", vector_valid, 1'b0);
        do_reti("prio_ret1", 8'h40, 2'd0);
        tick();
        check_eq("prio_vv3", vector_valid, 1'b1);
        check_eq("prio_addr3", vector_addr, 8'hFC);
        check_eq("prio_ack3", irq_ack, 4'b1000);
        seq_next_addr = 8'h50;
        tick();
        do_reti("prio_ret3", 8'h50, 2'd0);

        // Nesting
        take("nest_a", 4'b0100, 8'hF8, 8'h60);
        take("nest_b", 4'b0001, 8'hF0, 8'h70);
        check_eq("nest_depth", depth, 2'd2);
        do_reti("nest_ret1", 8'h70, 2'd1);
        do_reti("nest_ret2", 8'h60, 2'd0);

        // Masking with gie=0, then ei releases it
        di = 1'b1;
        tick();
        di = 1'b0;
        irq = 4'b0010;
        tick();
        irq = '0;
        tick();
        tick();
        check_eq("mask_none", vector_valid, 1'b0);
        ei = 1'b1;
        tick();
        ei = 1'b0;
        check_eq("mask_ei_edge", vector_valid, 1'b0);
        tick();
        check_eq("mask_vv", vector_valid, 1'b1);
        check_eq("mask_addr", vector_addr, 8'hF4);
        seq_next_addr = 8'h11;
        tick();
        do_reti("mask_ret", 8'h11, 2'd0);

        // Full stack holds a request back until a pop frees a slot
        take("full_3", 4'b1000, 8'hFC, 8'hA3);
        take("full_2", 4'b0100, 8'hF8, 8'hA2);
        take("full_1", 4'b0010, 8'hF4, 8'hA1);
        check_eq("full_depth", depth, 2'd3);
        irq = 4'b0001;
        tick();
        irq = '0;
        tick();
        check_eq("full_blk1", vector_valid, 1'b0);
        tick();
        check_eq("full_blk2", vector_valid, 1'b0);
        check_eq("full_depth2", depth, 2'd3);
        do_reti("full_ret1", 8'hA1, 2'd2);
        tick();
        check_eq("full_vv0", vector_valid, 1'b1);
        check_eq("full_addr0", vector_addr, 8'hF0);
        seq_next_addr = 8'hA0;
        tick();
        check_eq("full_depth3", depth, 2'd3);
        do_reti("full_ret0", 8'hA0, 2'd2);
        do_reti("full_ret2", 8'hA2, 2'd1);
        do_reti("full_ret3", 8'hA3, 2'd0);

        // Underflow is sticky
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check_eq("uf_set", underflow, 1'b1);
        check_eq("uf_no_rv", ret_valid, 1'b0);
        tick();
        tick();
        check_eq("uf_sticky", underflow, 1'b1);

        // reti coincident with a takeable request
        take("coin_a", 4'b0100, 8'hF8, 8'hB2);
        irq = 4'b0001;
        tick();
        irq = '0;
        do_reti("coin_ret", 8'hB2, 2'd0);
        tick();
        check_eq("coin_vv", vector_valid, 1'b1);
        check_eq("coin_addr", vector_addr, 8'hF0);
        seq_next_addr = 8'hB0;
        tick();
        do_reti("coin_ret2", 8'hB0, 2'd0);

        // ei and di together leave gie cleared
        ei = 1'b1;
        di = 1'b1;
        tick();
        ei = 1'b0;
        di = 1'b0;
        irq = 4'b0010;
        tick();
        irq = '0;
        tick();
        check_eq("eidi_none1", vector_valid, 1'b0);
        tick();
        check_eq("eidi_none2", vector_valid, 1'b0);

        // Reset mid-VECTOR: the pending irq 1 is taken once gie is set
        ei = 1'b1;
        tick();
        ei = 1'b0;
        tick();
        check_eq("rstv_vv", vector_valid, 1'b1);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        check_eq("rstv_vv0", vector_valid, 1'b0);
        check_eq("rstv_addr0", vector_addr, 8'h00);
        check_eq("rstv_ack0", irq_ack, 4'b0000);
        check_eq("rstv_depth", depth, 2'd0);
        check_eq("rstv_uf", underflow, 1'b0);
        ei = 1'b1;
        tick();
        ei = 1'b0;
        tick();
        tick();
        check_eq("rstv_no_pend", vector_valid, 1'b0);
        check_eq("rstv_depth2", depth, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
